// File: rtl/dijkstra_pkg.sv
// Shared constants and types for the graph loader feeding the shortest-path engine.
package dijkstra_pkg;

    localparam int unsigned EDGE_W     = 12;
    localparam int unsigned PARENT_LSB = 0;
    localparam int unsigned CHILD_LSB  = 4;
    localparam int unsigned WEIGHT_LSB = 8;
    localparam int unsigned MAX_NODES  = 15;
    localparam int unsigned MAX_EDGES  = 255;
    // Record slots in the packed output; one more than MAX_EDGES so e indexes every slot.
    localparam int unsigned NUM_SLOTS  = 256;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StLoad    = 2'd1,
        StPresent = 2'd2
    } state_e;

endpackage

// File: rtl/edge_checker.sv
// Combinational validity test for an incoming edge: both endpoints in 1..n, no
// self-loop, and room left in the edge store.
module edge_checker #(
    parameter int unsigned MAX_EDGES = 255
) (
    input  logic [3:0] parent,
    input  logic [3:0] child,
    input  logic [3:0] n,
    input  logic [7:0] e,
    output logic       edge_ok
);

    localparam logic [7:0] EdgeCap = 8'(MAX_EDGES);

    // Evaluate all acceptance rules for the offered edge.
    always_comb begin
        edge_ok = (parent != 4'd0) && (parent <= n) &&
                  (child  != 4'd0) && (child  <= n) &&
                  (parent != child) && (e < EdgeCap);
    end

endmodule

// File: rtl/graph_edge_packer.sv
// Collects a stream of (parent, child, weight) edges into a flat packed record
// array and presents the whole graph to the consumer with a valid/ready handshake.
module graph_edge_packer
    import dijkstra_pkg::state_e;
    import dijkstra_pkg::StIdle;
    import dijkstra_pkg::StLoad;
    import dijkstra_pkg::StPresent;
    import dijkstra_pkg::PARENT_LSB;
    import dijkstra_pkg::CHILD_LSB;
    import dijkstra_pkg::WEIGHT_LSB;
    import dijkstra_pkg::NUM_SLOTS;
#(
    parameter int unsigned MAX_EDGES = dijkstra_pkg::MAX_EDGES,
    parameter int unsigned EDGE_W    = dijkstra_pkg::EDGE_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [3:0]                    n_in,
    input  logic                          edge_valid,
    output logic                          edge_ready,
    input  logic [3:0]                    edge_parent,
    input  logic [3:0]                    edge_child,
    input  logic [3:0]                    edge_weight,
    input  logic                          edge_last,
    input  logic                          hold,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [3:0]                    n,
    output logic [7:0]                    e,
    output logic [NUM_SLOTS*EDGE_W-1:0]   data,
    output logic                          err
);

    localparam int unsigned DataW = NUM_SLOTS * EDGE_W;
    localparam int unsigned IdxW  = $clog2(DataW);

    state_e             state_q, state_d;
    logic [3:0]         n_q, n_d;
    logic [7:0]         e_q, e_d;
    logic [DataW-1:0]   data_q, data_d;
    logic               err_q, err_d;

    logic               accept;
    logic               start_ok;
    logic               edge_ok;
    logic [EDGE_W-1:0]  rec;
    logic [IdxW-1:0]    slot_lsb;

    edge_checker #(
        .MAX_EDGES (MAX_EDGES)
    ) u_edge_checker (
        .parent  (edge_parent),
        .child   (edge_child),
        .n       (n_q),
        .e       (e_q),
        .edge_ok (edge_ok)
    );

    assign start_ok = start && (n_in != 4'd0);
    assign accept   = edge_valid && edge_ready;
    // Next free slot sits directly above the e records already stored.
    assign slot_lsb = IdxW'(e_q) * IdxW'(EDGE_W);

    // Assemble the packed record for the offered edge.
    always_comb begin
        rec = '0;
        rec[PARENT_LSB +: 4] = edge_parent;
        rec[CHILD_LSB  +: 4] = edge_child;
        rec[WEIGHT_LSB +: 4] = edge_weight;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start_ok) state_d = StLoad;
            StLoad:    if (accept && edge_last) state_d = StPresent;
            StPresent: if (out_ready) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        edge_ready = (state_q == StLoad) && !hold;
        out_valid  = (state_q == StPresent);
    end

    // Datapath next-state: capture on start, store or drop on each accepted edge.
    always_comb begin
        n_d    = n_q;
        e_d    = e_q;
        data_d = data_q;
        err_d  = err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (start_ok) begin
                        n_d    = n_in;
                        e_d    = '0;
                        data_d = '0;
                        err_d  = 1'b0;
                    end else begin
                        err_d  = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (accept) begin
                    if (edge_ok) begin
                        data_d[slot_lsb +: EDGE_W] = rec;
                        e_d = e_q + 8'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_q    <= '0;
            e_q    <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            n_q    <= n_d;
            e_q    <= e_d;
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

    assign n    = n_q;
    assign e    = e_q;
    assign data = data_q;
    assign err  = err_q;

endmodule

// File: tb/tb_graph_edge_packer.sv
// Randomized bench for graph_edge_packer against a queue-based reference model.
module tb_graph_edge_packer;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    n_in;
    logic          edge_valid;
    logic          edge_ready;
    logic [3:0]    edge_parent;
    logic [3:0]    edge_child;
    logic [3:0]    edge_weight;
    logic          edge_last;
    logic          hold;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    n;
    logic [7:0]    e;
    logic [3071:0] data;
    logic          err;

    always #5 clk = ~clk;

    graph_edge_packer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .n_in        (n_in),
        .edge_valid  (edge_valid),
        .edge_ready  (edge_ready),
        .edge_parent (edge_parent),
        .edge_child  (edge_child),
        .edge_weight (edge_weight),
        .edge_last   (edge_last),
        .hold        (hold),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .n           (n),
        .e           (e),
        .data        (data),
        .err         (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: graph as a list of stored records plus two phase flags.
    bit          m_load;
    bit          m_present;
    bit          m_err;
    logic [3:0]  m_n;
    logic [11:0] m_recs[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_load    = 1'b0;
        m_present = 1'b0;
        m_err     = 1'b0;
        m_n       = 4'd0;
        m_recs.delete();
    endtask

    // Apply the effect of the current inputs at the coming clock edge.
    task automatic model_edge();
        bit good;
        if (!m_load && !m_present) begin
            if (start) begin
                if (n_in != 4'd0) begin
                    m_n = n_in;
                    m_recs.delete();
                    m_err  = 1'b0;
                    m_load = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end else if (m_load) begin
            if (edge_valid && !hold) begin
                good = (edge_parent >= 1) && (edge_parent <= m_n) &&
                       (edge_child >= 1) && (edge_child <= m_n) &&
                       (edge_parent != edge_child) && (m_recs.size() < 255);
                if (good) m_recs.push_back({edge_weight, edge_child, edge_parent});
                else m_err = 1'b1;
                if (edge_last) begin
                    m_load    = 1'b0;
                    m_present = 1'b1;
                end
            end
        end else if (out_ready) begin
            m_present = 1'b0;
        end
    endtask

    task automatic check_regs();
        check_eq("n", n, m_n);
        check_eq("e", e, m_recs.size());
        check_eq("err", err, m_err);
        for (int k = 0; k < 256; k++) begin
            logic [11:0] exp_rec;
            exp_rec = (k < m_recs.size()) ? m_recs[k] : 12'h000;
            check_eq($sformatf("rec%0d", k), data[k*12 +: 12], exp_rec);
        end
    endtask

    // One clock: check handshake outputs, advance model, then check registers.
    task automatic step();
        #1;
        check_eq("edge_ready", edge_ready, m_load && !hold);
        check_eq("out_valid", out_valid, m_present);
        model_edge();
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic idle_inputs();
        start       = 1'b0;
        n_in        = 4'd0;
        edge_valid  = 1'b0;
        edge_parent = 4'd0;
        edge_child  = 4'd0;
        edge_weight = 4'd0;
        edge_last   = 1'b0;
        hold        = 1'b0;
        out_ready   = 1'b0;
    endtask

    task automatic do_start(input logic [3:0] nn);
        start = 1'b1;
        n_in  = nn;
        step();
        start = 1'b0;
        n_in  = 4'd0;
    endtask

    task automatic send_edge(input logic [3:0] p, input logic [3:0] c, input logic [3:0] w,
                             input bit last);
        edge_valid  = 1'b1;
        edge_parent = p;
        edge_child  = c;
        edge_weight = w;
        edge_last   = last;
        step();
        edge_valid  = 1'b0;
        edge_last   = 1'b0;
    endtask

    // Offer an edge under random hold and stray start pulses until it is taken.
    task automatic send_edge_rand(input logic [3:0] p, input logic [3:0] c, input logic [3:0] w,
                                  input bit last);
        int  tries = 0;
        bit  acc;
        edge_valid  = 1'b1;
        edge_parent = p;
        edge_child  = c;
        edge_weight = w;
        edge_last   = last;
        do begin
            hold  = ($urandom_range(0, 3) == 0) && (tries < 8);
            start = 1'($urandom_range(0, 1));
            n_in  = 4'($urandom_range(0, 15));
            acc   = m_load && !hold;
            step();
            tries++;
        end while (!acc && tries < 16);
        check_eq("edge_taken", acc, 1'b1);
        hold       = 1'b0;
        start      = 1'b0;
        n_in       = 4'd0;
        edge_valid = 1'b0;
        edge_last  = 1'b0;
    endtask

    task automatic drain(input int stall);
        out_ready = 1'b0;
        repeat (stall) begin
            start = 1'($urandom_range(0, 1));
            n_in  = 4'($urandom_range(1, 15));
            step();
        end
        start     = 1'b0;
        n_in      = 4'd0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] p, c, w, nn;
        int         num;

        idle_inputs();
        model_clear();
        reset = 1'b0;
        #1;
        check_eq("rst_ready", edge_ready, 1'b0);
        check_eq("rst_ovalid", out_valid, 1'b0);
        check_regs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Zero nodes: error, stays idle, nothing accepted.
        do_start(4'd0);
        check_eq("zero_err", err, 1'b1);
        check_eq("zero_ready", edge_ready, 1'b0);
        send_edge(4'd1, 4'd2, 4'd3, 1'b1);
        check_eq("zero_e", e, 8'd0);
        check_eq("zero_ovalid", out_valid, 1'b0);

        // Basic load.
        do_start(4'd3);
        send_edge(4'd1, 4'd2, 4'd5, 1'b0);
        send_edge(4'd2, 4'd3, 4'd4, 1'b0);
        send_edge(4'd1, 4'd3, 4'd9, 1'b1);
        check_eq("basic_ovalid", out_valid, 1'b1);
        check_eq("basic_n", n, 4'd3);
        check_eq("basic_e", e, 8'd3);
        check_eq("basic_data", data[35:0], 36'h931432521);
        check_eq("basic_hi", |data[3071:36], 1'b0);
        check_eq("basic_err", err, 1'b0);
        drain(0);

        // Invalid edges are dropped but flagged.
        do_start(4'd4);
        send_edge(4'd0, 4'd2, 4'd1, 1'b0);
        send_edge(4'd5, 4'd1, 4'd1, 1'b0);
        send_edge(4'd2, 4'd2, 4'd3, 1'b0);
        send_edge(4'd1, 4'd4, 4'd7, 1'b1);
        check_eq("inv_err", err, 1'b1);
        check_eq("inv_e", e, 8'd1);
        check_eq("inv_data", data[11:0], 12'h741);
        drain(2);

        // Backpressure on both sides.
        do_start(4'd5);
        send_edge(4'd1, 4'd2, 4'd1, 1'b0);
        edge_valid  = 1'b1;
        edge_parent = 4'd2;
        edge_child  = 4'd3;
        edge_weight = 4'd2;
        hold        = 1'b1;
        repeat (3) step();
        check_eq("bp_e_frozen", e, 8'd1);
        check_eq("bp_ready_low", edge_ready, 1'b0);
        hold = 1'b0;
        send_edge(4'd2, 4'd3, 4'd2, 1'b0);
        send_edge(4'd3, 4'd4, 4'd3, 1'b0);
        send_edge(4'd4, 4'd5, 4'd4, 1'b1);
        check_eq("bp_e", e, 8'd4);
        out_ready = 1'b0;
        repeat (5) step();
        check_eq("bp_ovalid_held", out_valid, 1'b1);
        check_eq("bp_e_held", e, 8'd4);
        drain(0);

        // Reset mid-load discards the partial graph immediately.
        do_start(4'd4);
        send_edge(4'd1, 4'd2, 4'd3, 1'b0);
        send_edge(4'd2, 4'd3, 4'd4, 1'b0);
        edge_valid = 1'b1;
        reset      = 1'b0;
        #1;
        model_clear();
        check_eq("mrst_ready", edge_ready, 1'b0);
        check_eq("mrst_e", e, 8'd0);
        check_eq("mrst_data", |data, 1'b0);
        edge_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        do_start(4'd2);
        send_edge(4'd1, 4'd2, 4'd6, 1'b1);
        check_eq("mrst_e_after", e, 8'd1);
        check_eq("mrst_err_after", err, 1'b0);
        drain(1);

        // Overflow: 256 valid edges, only 255 fit.
        do_start(4'd15);
        for (int i = 0; i < 256; i++) begin
            p = 4'($urandom_range(1, 15));
            c = 4'(32'(p) % 15 + 1);
            w = 4'($urandom_range(0, 15));
            send_edge(p, c, w, i == 255);
        end
        check_eq("ovf_e", e, 8'd255);
        check_eq("ovf_err", err, 1'b1);
        check_eq("ovf_rec255", data[3071:3060], 12'h000);
        drain(0);

        // Random graphs with mixed valid/invalid edges, stalls and stray starts.
        for (int g = 0; g < 10; g++) begin
            nn = 4'($urandom_range(1, 15));
            do_start(nn);
            num = $urandom_range(1, 24);
            for (int i = 0; i < num; i++) begin
                if ($urandom_range(0, 4) == 0) begin
                    p = 4'($urandom_range(0, 15));
                    c = 4'($urandom_range(0, 15));
                end else begin
                    p = 4'($urandom_range(1, nn));
                    c = 4'($urandom_range(1, nn));
                end
                w = 4'($urandom_range(0, 15));
                send_edge_rand(p, c, w, i == num - 1);
            end
            drain($urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
